mmio_port_controller: RTL and testbench
=======================================

Name: mmio_port_controller

Overview:
- Memory-mapped I/O peripheral on the MEM-stage data bus, alongside the data RAM. It consumes the same Address, WriteData, MemWrite and MemRead signals that the pipelined MIPS core drives from its EX/MEM register.
- Provides the core's PortOut register, a synchronized PortIn with change detection, and a compare-match cycle timer with an interrupt line.
- The top level uses IOSelect to steer the MEM/WB read-data mux and to suppress RAM writes.

Parameters:
- BASE_ADDR, 32'h1001_0100, I/O window base; must be 32-byte aligned; window is 32 bytes.
- IN_WIDTH, 8, width of PortIn; zero-extended on reads.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- Address  in  32  MEM-stage byte address (ALU result).
- WriteData  in  32  MEM-stage store data.
- MemWrite  in  1  store strobe.
- MemRead  in  1  load strobe.
- PortIn  in  IN_WIDTH  asynchronous external input.
- ReadData  out  32  combinational load data.
- IOSelect  out  1  combinational; 1 when Address[31:5] == BASE_ADDR[31:5].
- PortOut  out  32  output register.
- Irq  out  1  interrupt request, level.

Behaviour:
- Register decode
  - Register index is Address[4:2]; Address[1:0] is ignored.
  - 0 PORT_OUT (RW), 1 PORT_IN (RO), 2 STATUS (RO, write-1-to-clear), 3 CTRL (RW, bits[2:0]), 4 TIMER_CMP (RW), 5 TIMER_CNT (RW), 6-7 reserved (read 0, writes ignored).
- Write and read timing
  - Writes take effect on the clk edge where IOSelect & MemWrite = 1.
  - ReadData = selected register when IOSelect & MemRead, else 32'h0. It is purely combinational (same cycle), so MEM/WB latches it.
  - Reads have no side effects.
- Reset values (async, reset=0)
  - PortOut = 0, CTRL = 0, STATUS = 0, TIMER_CNT = 0, TIMER_CMP = 32'hFFFF_FFFF.
  - Synchronizer flops = 0, Irq = 0.
  - Reset asserted mid-operation clears everything immediately, including a pending sticky flag.
- Input path
  - 3 flops: s1<=PortIn, s2<=s1, s3<=s2.
  - PORT_IN reads {zeros, s2}.
  - STATUS[0] (in_changed) sets on the edge where s2 != s3.
  - Latency: a PortIn change sampled at edge k is readable after edge k+1; STATUS[0] is set after edge k+2.
- STATUS
  - bit0 in_changed, bit1 tmr_match; upper bits read 0.
  - A write with WriteData[i]=1 clears bit i. A set event in the same cycle as a clear wins (bit stays 1).
- CTRL
  - bit0 tmr_en, bit1 irq_in_en, bit2 irq_tmr_en.
- Timer, when tmr_en=1
  - If TIMER_CNT == TIMER_CMP: TIMER_CNT <= 0 and STATUS[1] sets.
  - Else TIMER_CNT <= TIMER_CNT+1.
  - Period is CMP+1 cycles. CMP=0 gives a match every cycle.
  - When tmr_en=0 the counter holds.
  - A CPU write to TIMER_CNT overrides the increment/wrap that cycle; no match is flagged that cycle.
  - A write to TIMER_CMP takes effect for the comparison starting the next cycle.
  - The 32-bit counter never passes CMP, so there is no overflow beyond CMP.
- Irq = (STATUS[0] & CTRL[1]) | (STATUS[1] & CTRL[2]). It is combinational from registers, so it changes one cycle after the flag or enable is written.
- Simultaneous read and write of the same register: ReadData shows the pre-write value.

Test Plan:
- Reset low, then high; read offsets 0x00,0x08,0x0C,0x10,0x14 -> 0, 0, 0, FFFF_FFFF, 0; Irq=0, PortOut=0.
- Store 0xDEADBEEF to 0x10010100 -> PortOut=DEADBEEF after that edge. Store to 0x10010118 (reserved) -> no change, read 0. Store to 0x10010200 -> IOSelect=0, PortOut unchanged.
- PortIn 0x00->0xA5 before edge k -> PORT_IN reads 0x000000A5 after k+1, STATUS=1 after k+2. Write STATUS=1 -> STATUS=0. Repeat with a PortIn change whose set coincides with the clear -> STATUS stays 1.
- CMP=3, CTRL=0x5 -> count sequence 0,1,2,3,0; STATUS[1] and Irq rise on the wrap edge. Clear STATUS -> Irq=0 until the next wrap 4 cycles later.
- Timer running, write TIMER_CNT=2 on the cycle CNT==CMP=3 -> CNT=2, no match flag. CMP=0 -> match every cycle.
- Assert reset mid-count with flags set -> all registers at reset values immediately, Irq=0 asynchronously.

Source files
------------

// File: rtl/mmio_port_controller.sv
// Memory-mapped I/O block on the MEM-stage bus: output port, synchronized input
// port with change flag, compare-match timer and a level interrupt.
module mmio_port_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0100,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                IOSelect,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  localparam logic [2:0] REG_PORT_OUT = 3'd0;
  localparam logic [2:0] REG_PORT_IN  = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_TMR_CMP  = 3'd4;
  localparam logic [2:0] REG_TMR_CNT  = 3'd5;

  logic [31:0]         r_port_out;
  logic [IN_WIDTH-1:0] r_s1, r_s2, r_s3;
  logic [1:0]          r_status;
  logic [2:0]          r_ctrl;
  logic [31:0]         r_cmp;
  logic [31:0]         r_cnt;

  logic        w_sel;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_cnt_wr;
  logic        w_match;
  logic [1:0]  w_status_set;
  logic [1:0]  w_status_clr;
  logic [31:0] w_in_ext;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_sel         = (Address[31:5] == BASE_ADDR[31:5]);
  assign w_idx         = Address[4:2];
  assign w_wr          = w_sel & MemWrite;
  assign w_unused_addr = ^Address[1:0];
  assign w_in_ext      = 32'(r_s2);

  // A CPU write to the counter pre-empts both the increment and the match.
  assign w_cnt_wr      = w_wr && (w_idx == REG_TMR_CNT);
  assign w_match       = r_ctrl[0] && !w_cnt_wr && (r_cnt == r_cmp);

  assign w_status_set  = {w_match, (r_s2 != r_s3)};
  assign w_status_clr  = (w_wr && (w_idx == REG_STATUS)) ? WriteData[1:0] : 2'b00;

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel && MemRead) begin
      case (w_idx)
        REG_PORT_OUT: w_rdata = r_port_out;
        REG_PORT_IN:  w_rdata = w_in_ext;
        REG_STATUS:   w_rdata = {30'h0, r_status};
        REG_CTRL:     w_rdata = {29'h0, r_ctrl};
        REG_TMR_CMP:  w_rdata = r_cmp;
        REG_TMR_CNT:  w_rdata = r_cnt;
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= 32'h0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_status   <= 2'b00;
      r_ctrl     <= 3'b000;
      r_cmp      <= 32'hFFFF_FFFF;
      r_cnt      <= 32'h0;
    end else begin
      r_s1 <= PortIn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_wr && (w_idx == REG_PORT_OUT)) r_port_out <= WriteData;
      if (w_wr && (w_idx == REG_CTRL))     r_ctrl     <= WriteData[2:0];
      if (w_wr && (w_idx == REG_TMR_CMP))  r_cmp      <= WriteData;

      if (w_cnt_wr)
        r_cnt <= WriteData;
      else if (r_ctrl[0])
        r_cnt <= w_match ? 32'h0 : r_cnt + 32'd1;

      // Set beats clear when both land on the same edge.
      r_status <= w_status_set | (r_status & ~w_status_clr);
    end
  end

  assign ReadData = w_rdata;
  assign IOSelect = w_sel;
  assign PortOut  = r_port_out;
  assign Irq      = (r_status[0] & r_ctrl[1]) | (r_status[1] & r_ctrl[2]);

endmodule

// File: tb/tb_mmio_port_controller.sv
// Scoreboard bench for mmio_port_controller: expected load data is queued when
// a read is driven and compared once ReadData settles.
module tb_mmio_port_controller;

  localparam logic [31:0] BASE = 32'h1001_0100;
  localparam logic [31:0] A_POUT = BASE + 32'h00;
  localparam logic [31:0] A_PIN  = BASE + 32'h04;
  localparam logic [31:0] A_STAT = BASE + 32'h08;
  localparam logic [31:0] A_CTRL = BASE + 32'h0C;
  localparam logic [31:0] A_CMP  = BASE + 32'h10;
  localparam logic [31:0] A_CNT  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        IOSelect;
  logic [31:0] PortOut;
  logic        Irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  mmio_port_controller #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .ReadData (ReadData),
    .IOSelect (IOSelect),
    .PortOut  (PortOut),
    .Irq      (Irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    sb_t x;
    Address = a;
    MemRead = 1'b1;
    sb.push_back('{tag, e});
    #1;
    x = sb.pop_front();
    chk(x.tag, ReadData, x.exp);
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset values
    @(negedge clk);
    rd(A_POUT, 32'h0, "rst_pout");
    rd(A_STAT, 32'h0, "rst_stat");
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_CMP,  32'hFFFF_FFFF, "rst_cmp");
    rd(A_CNT,  32'h0, "rst_cnt");
    chk("rst_irq", 32'(Irq), 32'h0);
    chk("rst_portout", PortOut, 32'h0);

    // Stores: mapped, reserved, outside window
    @(negedge clk); wr(A_POUT, 32'hDEAD_BEEF);
    chk("pout_store", PortOut, 32'hDEAD_BEEF);
    @(negedge clk); wr(BASE + 32'h18, 32'h1234_5678);
    chk("pout_resv_wr", PortOut, 32'hDEAD_BEEF);
    @(negedge clk); rd(BASE + 32'h18, 32'h0, "resv_rd");
    Address = BASE + 32'h1C; #1;
    chk("iosel_in", 32'(IOSelect), 32'h1);
    Address = 32'h1001_0200; #1;
    chk("iosel_out", 32'(IOSelect), 32'h0);
    wr(32'h1001_0200, 32'h0);
    chk("pout_outside", PortOut, 32'hDEAD_BEEF);
    @(negedge clk); rd(32'h1001_0200, 32'h0, "rd_outside");

    // Read and write of the same register in one cycle shows the old value
    @(negedge clk);
    Address = A_POUT; WriteData = 32'h1234_5678; MemWrite = 1'b1;
    rd(A_POUT, 32'hDEAD_BEEF, "rw_pre");
    @(posedge clk); #1; MemWrite = 1'b0;
    chk("rw_post", PortOut, 32'h1234_5678);

    // Input synchronizer latency and sticky change flag
    @(negedge clk); PortIn = 8'hA5;
    @(negedge clk);
    rd(A_PIN,  32'h0, "pin_k");
    rd(A_STAT, 32'h0, "stat_k");
    @(negedge clk);
    rd(A_PIN,  32'h0000_00A5, "pin_k1");
    rd(A_STAT, 32'h0, "stat_k1");
    @(negedge clk);
    rd(A_STAT, 32'h1, "stat_k2");
    @(negedge clk); wr(A_STAT, 32'h1);
    @(negedge clk); rd(A_STAT, 32'h0, "stat_clr");
    PortIn = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rd(A_PIN, 32'h0000_005A, "pin_5a");
    wr(A_STAT, 32'h1);
    @(negedge clk); rd(A_STAT, 32'h1, "stat_set_wins");
    chk("irq_in_masked", 32'(Irq), 32'h0);

    // Timer CMP=3, count sequence and wrap interrupt
    @(negedge clk); wr(A_CNT, 32'h0);
    @(negedge clk); wr(A_CMP, 32'h3);
    @(negedge clk); wr(A_STAT, 32'h3);
    @(negedge clk); wr(A_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd(A_CNT,  32'(i % 4), "tmr_seq");
      rd(A_STAT, (i == 4) ? 32'h2 : 32'h0, "tmr_stat");
      chk("tmr_irq", 32'(Irq), (i == 4) ? 32'h1 : 32'h0);
    end
    wr(A_STAT, 32'h2);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rd(A_CNT, 32'((j + 1) % 4), "tmr_seq2");
      chk("tmr_irq2", 32'(Irq), (j == 3) ? 32'h1 : 32'h0);
    end

    // Counter write on the match cycle overrides wrap and suppresses the flag
    wr(A_STAT, 32'h2);
    @(negedge clk); rd(A_CNT, 32'h1, "ovr_c1");
    @(negedge clk); rd(A_CNT, 32'h2, "ovr_c2");
    @(negedge clk); rd(A_CNT, 32'h3, "ovr_c3");
    wr(A_CNT, 32'h2);
    @(negedge clk);
    rd(A_CNT,  32'h2, "ovr_cnt");
    rd(A_STAT, 32'h0, "ovr_nomatch");
    chk("ovr_irq", 32'(Irq), 32'h0);

    // CMP=0 matches every cycle; a clear on a match edge loses to the set
    wr(A_CTRL, 32'h0);
    @(negedge clk); wr(A_CNT, 32'h0);
    @(negedge clk); wr(A_STAT, 32'h3);
    @(negedge clk); wr(A_CMP, 32'h0);
    @(negedge clk); wr(A_CTRL, 32'h1);
    @(negedge clk);
    rd(A_STAT, 32'h0, "cmp0_pre");
    rd(A_CNT,  32'h0, "cmp0_cnt0");
    wr(A_STAT, 32'h2);
    @(negedge clk);
    rd(A_STAT, 32'h2, "cmp0_match");
    rd(A_CNT,  32'h0, "cmp0_cnt1");
    @(negedge clk);
    rd(A_CNT,  32'h0, "cmp0_cnt2");

    // Asynchronous reset mid-count with flags set
    wr(A_CMP, 32'd100);
    @(negedge clk); wr(A_CTRL, 32'h7);
    @(negedge clk);
    chk("pre_rst_irq", 32'(Irq), 32'h1);
    rd(A_STAT, 32'h2, "pre_rst_stat");
    rd(A_CNT,  32'h1, "pre_rst_cnt");
    reset = 1'b0;
    #1;
    chk("arst_irq", 32'(Irq), 32'h0);
    chk("arst_portout", PortOut, 32'h0);
    rd(A_STAT, 32'h0, "arst_stat");
    rd(A_CTRL, 32'h0, "arst_ctrl");
    rd(A_CMP,  32'hFFFF_FFFF, "arst_cmp");
    rd(A_CNT,  32'h0, "arst_cnt");
    rd(A_PIN,  32'h0, "arst_pin");
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    rd(A_CNT, 32'h0, "post_rst_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
